// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared types and constants for the VGA timing generator:
//               test-pattern enum, colour-bar palette and the default
//               640x480 timing values.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    typedef enum logic [1:0] {
        PAT_CHECK = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_RAMP  = 2'd2,
        PAT_WHITE = 2'd3
    } pattern_e;

    // Colour-bar palette, packed as {r, g, b}
    localparam logic [23:0] c_bar_white   = 24'hFFFFFF;
    localparam logic [23:0] c_bar_yellow  = 24'hFFFF00;
    localparam logic [23:0] c_bar_cyan    = 24'h00FFFF;
    localparam logic [23:0] c_bar_green   = 24'h00FF00;
    localparam logic [23:0] c_bar_magenta = 24'hFF00FF;
    localparam logic [23:0] c_bar_red     = 24'hFF0000;
    localparam logic [23:0] c_bar_blue    = 24'h0000FF;
    localparam logic [23:0] c_bar_black   = 24'h000000;

    // Default 640x480@60 timing
    localparam int c_def_h_active = 640;
    localparam int c_def_h_fp     = 16;
    localparam int c_def_h_sync   = 96;
    localparam int c_def_h_bp     = 48;
    localparam int c_def_v_active = 480;
    localparam int c_def_v_fp     = 10;
    localparam int c_def_v_sync   = 2;
    localparam int c_def_v_bp     = 33;

    // Bar colour for bar index 0 (leftmost) .. 7 (rightmost)
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] col;
        case (idx)
            3'd0:    col = c_bar_white;
            3'd1:    col = c_bar_yellow;
            3'd2:    col = c_bar_cyan;
            3'd3:    col = c_bar_green;
            3'd4:    col = c_bar_magenta;
            3'd5:    col = c_bar_red;
            3'd6:    col = c_bar_blue;
            default: col = c_bar_black;
        endcase
        return col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis: a wrapping position counter with active-area
//               and sync-window decode. Used once for h and once for v.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int CW     = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          advance,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          active,
    output logic          sync
);

    localparam int            c_total      = ACTIVE + FP + SYNC + BP;
    localparam logic [CW-1:0] c_last       = CW'(c_total - 1);
    localparam logic [CW-1:0] c_active     = CW'(ACTIVE);
    localparam logic [CW-1:0] c_sync_start = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] c_sync_end   = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next position: step on advance, wrap to 0 after the last position
    always_comb begin
        count_d = count_q;
        wrap    = 1'b0;
        if (advance) begin
            if (count_q == c_last) begin
                count_d = '0;
                wrap    = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Position register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign active = (count_q < c_active);
    assign sync   = ((count_q >= c_sync_start) && (count_q < c_sync_end)) ? POL : ~POL;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator with optional
//               built-in test-pattern source. All outputs are registered and
//               lag the internal (h,v) counters by one clock.
//               Build option: define VGA_TPG_EN to compile in the pattern
//               generator; otherwise r/g/b are tied to 0.
//               The pattern source needs CW >= 8 (ramp uses x[7:0]).
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = c_def_h_active,
    parameter int H_FP     = c_def_h_fp,
    parameter int H_SYNC   = c_def_h_sync,
    parameter int H_BP     = c_def_h_bp,
    parameter int V_ACTIVE = c_def_v_active,
    parameter int V_FP     = c_def_v_fp,
    parameter int V_SYNC   = c_def_v_sync,
    parameter int V_BP     = c_def_v_bp,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic [1:0]    pattern_sel,
    output logic          hsync,
    output logic          vsync,
    output logic          pixel_valid,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b
);

    logic [CW-1:0] w_h_count, w_v_count;
    logic          w_h_wrap, w_v_wrap;
    logic          w_h_active, w_v_active;
    logic          w_h_sync, w_v_sync;
    logic          w_h_origin;
    logic [23:0]   w_pixel_rgb;

    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          pixel_valid_q, pixel_valid_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic [23:0]   rgb_q, rgb_d;
    // Set while the counters sit at (0,0); driven from the vertical wrap
    logic          frame_origin_q, frame_origin_d;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP),
        .POL    (HS_POL),   .CW (CW)
    ) u_h_axis (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (enable),
        .count   (w_h_count),
        .wrap    (w_h_wrap),
        .active  (w_h_active),
        .sync    (w_h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP),
        .POL    (VS_POL),   .CW (CW)
    ) u_v_axis (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (w_h_wrap),
        .count   (w_v_count),
        .wrap    (w_v_wrap),
        .active  (w_v_active),
        .sync    (w_v_sync)
    );

    assign w_h_origin = (w_h_count == '0);

`ifdef VGA_TPG_EN
    localparam int c_bar_w = H_ACTIVE / 8;

    pattern_e   pat_q, pat_d;
    logic [2:0] w_bar_idx;

    // Pattern select is captured on the frame-origin pixel so it applies from that pixel on
    always_comb begin
        pat_d = pat_q;
        if (enable && frame_origin_q) begin
            pat_d = pattern_e'(pattern_sel);
        end
    end

    // Latched pattern register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q <= PAT_CHECK;
        end else begin
            pat_q <= pat_d;
        end
    end

    // Bar index: number of bar boundaries already passed on this line
    always_comb begin
        w_bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (w_h_count >= CW'(i * c_bar_w)) begin
                w_bar_idx = 3'(i);
            end
        end
    end

    // Pattern colour for the current counter position
    always_comb begin
        w_pixel_rgb = 24'h000000;
        case (pat_d)
            PAT_CHECK: w_pixel_rgb = (w_h_count[5] ^ w_v_count[5]) ? 24'hFFFFFF : 24'h000000;
            PAT_BARS:  w_pixel_rgb = bar_color(w_bar_idx);
            PAT_RAMP:  w_pixel_rgb = {3{w_h_count[7:0]}};
            default:   w_pixel_rgb = 24'hFFFFFF;
        endcase
    end
`else
    logic w_unused_pattern_sel;

    assign w_unused_pattern_sel = ^pattern_sel;
    assign w_pixel_rgb          = 24'h000000;
`endif

    // Output next-state: track the counters while enabled, hold/blank otherwise
    always_comb begin
        x_d            = x_q;
        y_d            = y_q;
        hsync_d        = hsync_q;
        vsync_d        = vsync_q;
        pixel_valid_d  = 1'b0;
        line_start_d   = 1'b0;
        frame_start_d  = 1'b0;
        rgb_d          = 24'h000000;
        frame_origin_d = frame_origin_q;
        if (enable) begin
            x_d            = w_h_count;
            y_d            = w_v_count;
            hsync_d        = w_h_sync;
            // vsync only moves at line start so it spans whole lines
            if (w_h_origin) begin
                vsync_d = w_v_sync;
            end
            pixel_valid_d  = w_h_active & w_v_active;
            line_start_d   = w_h_origin;
            frame_start_d  = frame_origin_q;
            frame_origin_d = w_v_wrap;
            if (w_h_active & w_v_active) begin
                rgb_d = w_pixel_rgb;
            end
        end
    end

    // Output registers with asynchronous reset to idle levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q            <= '0;
            y_q            <= '0;
            hsync_q        <= ~HS_POL;
            vsync_q        <= ~VS_POL;
            pixel_valid_q  <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            rgb_q          <= 24'h000000;
            frame_origin_q <= 1'b1;
        end else begin
            x_q            <= x_d;
            y_q            <= y_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            pixel_valid_q  <= pixel_valid_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            rgb_q          <= rgb_d;
            frame_origin_q <= frame_origin_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign pixel_valid = pixel_valid_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign r           = rgb_q[23:16];
    assign g           = rgb_q[15:8];
    assign b           = rgb_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen in a small 14x8 mode
//               (H 8/2/3/1, V 4/1/2/1, active-low syncs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [1:0]    pattern_sel;
    logic          hsync, vsync, pixel_valid, line_start, frame_start;
    logic [CW-1:0] x, y;
    logic [7:0]    r, g, b;

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HS_POL   (1'b0), .VS_POL (1'b0), .CW (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .hsync       (hsync),
        .vsync       (vsync),
        .pixel_valid (pixel_valid),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .r           (r),
        .g           (g),
        .b           (b)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          mh, mv, m_pat;
    int          e_x, e_y;
    logic        e_pv, e_ls, e_fs, e_hs, e_vs;
    logic [23:0] e_rgb;

    function automatic logic [23:0] model_rgb(input int px, input int py, input int pat, input logic pv);
        logic [23:0] c;
        logic [7:0]  p8;
        p8 = px[7:0];
        c  = 24'h000000;
        if (pv) begin
            case (pat)
                0: c = (((px >> 5) ^ (py >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
                1: case (px)
                       0: c = 24'hFFFFFF;
                       1: c = 24'hFFFF00;
                       2: c = 24'h00FFFF;
                       3: c = 24'h00FF00;
                       4: c = 24'hFF00FF;
                       5: c = 24'hFF0000;
                       6: c = 24'h0000FF;
                       default: c = 24'h000000;
                   endcase
                2: c = {p8, p8, p8};
                default: c = 24'hFFFFFF;
            endcase
        end
`ifdef VGA_TPG_EN
        return c;
`else
        return (c & 24'h000000);
`endif
    endfunction

    // One clock with the given enable; predicts and checks every output
    task automatic step(input logic en);
        enable = en;
        @(posedge clk);
        #1;
        if (en) begin
            e_x  = mh;
            e_y  = mv;
            e_pv = (mh < 8) && (mv < 4);
            e_ls = (mh == 0);
            e_fs = (mh == 0) && (mv == 0);
            e_hs = (mh >= 10 && mh < 13) ? 1'b0 : 1'b1;
            if (mh == 0) e_vs = (mv >= 5 && mv < 7) ? 1'b0 : 1'b1;
            if (e_fs) m_pat = int'(pattern_sel);
            e_rgb = model_rgb(mh, mv, m_pat, e_pv);
            mh = mh + 1;
            if (mh == 14) begin
                mh = 0;
                mv = (mv == 7) ? 0 : mv + 1;
            end
        end else begin
            e_pv  = 1'b0;
            e_ls  = 1'b0;
            e_fs  = 1'b0;
            e_rgb = 24'h000000;
        end
        check("x", 32'(x), 32'(e_x));
        check("y", 32'(y), 32'(e_y));
        check("pixel_valid", 32'(pixel_valid), 32'(e_pv));
        check("line_start", 32'(line_start), 32'(e_ls));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("hsync", 32'(hsync), 32'(e_hs));
        check("vsync", 32'(vsync), 32'(e_vs));
        check("rgb", 32'({r, g, b}), 32'(e_rgb));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"}, 32'(x), 0);
        check({tag, "_y"}, 32'(y), 0);
        check({tag, "_pv"}, 32'(pixel_valid), 0);
        check({tag, "_ls"}, 32'(line_start), 0);
        check({tag, "_fs"}, 32'(frame_start), 0);
        check({tag, "_hs"}, 32'(hsync), 1);
        check({tag, "_vs"}, 32'(vsync), 1);
        check({tag, "_rgb"}, 32'({r, g, b}), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic en;
        int   x;
        int   y;
        logic pv;
        logic ls;
        logic fs;
        logic hs;
    } vec_t;

    vec_t vecs [21];

    logic [23:0] c_x0_col;

    initial begin
        int n, vs_low, pv_cnt, pv_bad, ls_cnt, hs_low, edge_bad;
        logic prev_vs;

`ifdef VGA_TPG_EN
        c_x0_col = 24'hFFFFFF;
`else
        c_x0_col = 24'h000000;
`endif
        //            en    x   y  pv    ls    fs    hs
        vecs[0]  = '{1'b1,  0, 0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1'b1,  1, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1,  2, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1,  3, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1,  4, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1,  5, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1,  6, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1,  7, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1,  8, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1,  9, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 10, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 11, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 12, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 13, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b1,  0, 1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b1,  1, 1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b1,  2, 1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b1,  3, 1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b0,  3, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{1'b0,  3, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{1'b1,  4, 1, 1'b1, 1'b0, 1'b0, 1'b1};

        reset_n     = 1'b0;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        #12;
        check_reset_outputs("reset");
        #1;
        reset_n = 1'b1;

        // First line and a short enable-low gap from the table
        for (int i = 0; i < 21; i++) begin
            enable = vecs[i].en;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_x", i), 32'(x), 32'(vecs[i].x));
            check($sformatf("tbl%0d_y", i), 32'(y), 32'(vecs[i].y));
            check($sformatf("tbl%0d_pv", i), 32'(pixel_valid), 32'(vecs[i].pv));
            check($sformatf("tbl%0d_ls", i), 32'(line_start), 32'(vecs[i].ls));
            check($sformatf("tbl%0d_fs", i), 32'(frame_start), 32'(vecs[i].fs));
            check($sformatf("tbl%0d_hs", i), 32'(hsync), 32'(vecs[i].hs));
            check($sformatf("tbl%0d_vs", i), 32'(vsync), 1);
            check($sformatf("tbl%0d_rgb", i), 32'({r, g, b}), 0);
        end

        // Hand the run over to the model: next counter position is (5,1)
        mh = 5; mv = 1; m_pat = 0;
        e_x = 4; e_y = 1; e_hs = 1'b1; e_vs = 1'b1;

        // Full frame statistics between two frame_start pulses
        n = 0;
        while (frame_start !== 1'b1 && n < 200) begin
            step(1'b1);
            n++;
        end
        check("wait_fs", 32'(frame_start), 1);
        n = 0; vs_low = 0; pv_cnt = 0; pv_bad = 0; ls_cnt = 0; hs_low = 0; edge_bad = 0;
        prev_vs = vsync;
        do begin
            step(1'b1);
            n++;
            if (vsync == 1'b0) begin
                vs_low++;
                if (y < 5 || y > 6) edge_bad++;
            end
            if (vsync != prev_vs && !line_start) edge_bad++;
            prev_vs = vsync;
            if (pixel_valid) pv_cnt++;
            if (pixel_valid && y >= 4) pv_bad++;
            if (line_start) ls_cnt++;
            if (!hsync) hs_low++;
        end while (frame_start !== 1'b1 && n < 300);
        check("frame_period", 32'(n), 112);
        check("vsync_low_clocks", 32'(vs_low), 28);
        check("vsync_placement", 32'(edge_bad), 0);
        check("pv_count", 32'(pv_cnt), 32);
        check("pv_below_active", 32'(pv_bad), 0);
        check("line_start_count", 32'(ls_cnt), 8);
        check("hsync_low_clocks", 32'(hs_low), 24);

        // Enable low for 20 clocks at x=3, then resume at x=4
        n = 0;
        while (!(x == 3 && pixel_valid) && n < 200) begin
            step(1'b1);
            n++;
        end
        check("wait_x3", 32'(x), 3);
        for (int i = 0; i < 20; i++) step(1'b0);
        check("frozen_x", 32'(x), 3);
        check("frozen_strobes", 32'({pixel_valid, line_start, frame_start}), 0);
        step(1'b1);
        check("resume_x", 32'(x), 4);

        // Pattern change mid-frame takes effect at the next frame_start
        n = 0;
        while (y != 2 && n < 200) begin
            step(1'b1);
            n++;
        end
        check("wait_y2", 32'(y), 2);
        pattern_sel = 2'd1;
        n = 0;
        do begin
            step(1'b1);
            n++;
            if (frame_start !== 1'b1) check("pre_switch_rgb", 32'({r, g, b}), 0);
        end while (frame_start !== 1'b1 && n < 200);
        check("bars_x0", 32'({r, g, b}), 32'(c_x0_col));
        for (int i = 0; i < 7; i++) step(1'b1);
        check("bars_x7_pos", 32'(x), 7);
        check("bars_x7", 32'({r, g, b}), 0);

        // Ramp and solid white over whole frames, model-checked
        pattern_sel = 2'd2;
        for (int i = 0; i < 130; i++) step(1'b1);
        pattern_sel = 2'd3;
        for (int i = 0; i < 130; i++) step(1'b1);

        // Asynchronous reset mid-frame at (5,2)
        n = 0;
        while (!(x == 5 && y == 2) && n < 300) begin
            step(1'b1);
            n++;
        end
        check("wait_x5y2", 32'({y, x}), 32'({12'd2, 12'd5}));
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        pattern_sel = 2'd0;
        #2;
        reset_n = 1'b1;
        mh = 0; mv = 0; e_hs = 1'b1; e_vs = 1'b1;
        step(1'b1);
        check("restart", 32'({frame_start, line_start, pixel_valid, x, y}),
              32'({1'b1, 1'b1, 1'b1, 12'd0, 12'd0}));
        for (int i = 0; i < 112; i++) step(1'b1);
        check("restart_period_fs", 32'(frame_start), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
